// File: rtl/wd_pkg.sv
// Shared types and constants for the watchdog supervisor.
package wd_pkg;

   localparam int RETRY_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_MUTE    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_LOCKOUT = 3'd5
   } wd_state_e;

endpackage

// File: rtl/wd_hb_aggregator.sv
// Collects one liveness pulse from every source and emits a single registered heartbeat.
module wd_hb_aggregator #(
   parameter int N_SRC = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [N_SRC-1:0] src_alive,
   output logic             hb_out
);

   logic [N_SRC-1:0] seen_q, seen_d, merged;
   logic             hb_q, hb_d;

   // Pulses landing in the completing cycle are absorbed by that heartbeat.
   always_comb begin
      merged = seen_q | src_alive;
      seen_d = '0;
      hb_d   = 1'b0;
      if (en) begin
         if (&merged) begin
            hb_d = 1'b1;
         end else begin
            seen_d = merged;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seen_q <= '0;
         hb_q   <= 1'b0;
      end else begin
         seen_q <= seen_d;
         hb_q   <= hb_d;
      end
   end

   assign hb_out = hb_q;

endmodule

// File: rtl/wd_supervisor.sv
// Arms the watchdog, feeds it an aggregated heartbeat and runs the mute/reset/settle
// recovery on expiry, locking out after repeated failures.
//
// state   | meaning
// IDLE    | supervision off, RF muted, subsystem running
// ARMED   | watchdog enabled, heartbeats forwarded, RF live
// MUTE    | one cycle of RF mute before the subsystem reset
// HOLD    | subsystem held in reset for HOLD_CYCLES
// SETTLE  | reset released, waiting SETTLE_CYCLES before re-arm
// LOCKOUT | too many recoveries; waits for clear_lockout
module wd_supervisor
   import wd_pkg::*;
#(
   parameter int N_SRC         = 4,
   parameter int HOLD_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3,
   parameter int HEALTHY_BEATS = 8,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_SRC-1:0]   src_alive,
   input  logic               arm_req,
   input  logic               clear_lockout,
   input  logic               wd_triggered,
   input  logic               wd_warning,
   output logic               wd_heartbeat,
   output logic               wd_enable,
   output logic               wd_force_reset,
   output logic               rf_mute,
   output logic               sub_rstn,
   output logic               warn_irq,
   output logic [2:0]         state,
   output logic [RETRY_W-1:0] retry_count,
   output logic               lockout
);

   localparam int BEAT_W = $clog2(HEALTHY_BEATS + 1);

   wd_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic               en_q, en_d;
   logic               mute_q, mute_d;
   logic               srst_q, srst_d;
   logic               frc_q, frc_d;
   logic               lock_q, lock_d;
   logic               warn_irq_q, warn_irq_d;
   logic               warn_in_q;
   logic               hb;

   wd_hb_aggregator #(
      .N_SRC(N_SRC)
   ) u_hb_agg (
      .clk      (clk),
      .rstn     (rstn),
      .en       (state_q == ST_ARMED),
      .src_alive(src_alive),
      .hb_out   (hb)
   );

   assign retry_inc = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      retry_d = retry_q;

      case (state_q)
         ST_IDLE: begin
            if (arm_req) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (hb) begin
               if (beat_q == BEAT_W'(HEALTHY_BEATS - 1)) begin
                  beat_d  = '0;
                  retry_d = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            if (wd_triggered)  state_d = ST_MUTE;
            else if (!arm_req) state_d = ST_IDLE;
         end
         ST_MUTE: begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               retry_d = retry_inc;
               if (retry_inc >= RETRY_W'(MAX_RETRIES)) state_d = ST_LOCKOUT;
               else if (arm_req)                      state_d = ST_ARMED;
               else                                   state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (clear_lockout) begin
               state_d = ST_IDLE;
               retry_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ARMED && state_q != ST_ARMED) beat_d = '0;

      // Outputs are registered from the next state so they line up with state_q.
      en_d       = (state_d == ST_ARMED);
      mute_d     = (state_d != ST_ARMED);
      srst_d     = (state_d != ST_HOLD);
      lock_d     = (state_d == ST_LOCKOUT);
      frc_d      = (state_d != state_q) && (state_d == ST_ARMED || state_d == ST_HOLD);
      warn_irq_d = wd_warning & ~warn_in_q & (state_q == ST_ARMED);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         beat_q     <= '0;
         retry_q    <= '0;
         en_q       <= 1'b0;
         mute_q     <= 1'b1;
         srst_q     <= 1'b0;
         frc_q      <= 1'b0;
         lock_q     <= 1'b0;
         warn_irq_q <= 1'b0;
         warn_in_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         retry_q    <= retry_d;
         en_q       <= en_d;
         mute_q     <= mute_d;
         srst_q     <= srst_d;
         frc_q      <= frc_d;
         lock_q     <= lock_d;
         warn_irq_q <= warn_irq_d;
         warn_in_q  <= wd_warning;
      end
   end

   assign wd_heartbeat   = hb;
   assign wd_enable      = en_q;
   assign wd_force_reset = frc_q;
   assign rf_mute        = mute_q;
   assign sub_rstn       = srst_q;
   assign warn_irq       = warn_irq_q;
   assign state          = state_q;
   assign retry_count    = retry_q;
   assign lockout        = lock_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Vector-table bench for wd_supervisor with small recovery parameters.
module tb_wd_supervisor;
   import wd_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic [1:0] src_alive = '0;
   logic       arm_req = 1'b0;
   logic       clear_lockout = 1'b0;
   logic       wd_triggered = 1'b0;
   logic       wd_warning = 1'b0;
   logic       wd_heartbeat, wd_enable, wd_force_reset, rf_mute, sub_rstn, warn_irq, lockout;
   logic [2:0] state;
   logic [7:0] retry_count;

   always #5 clk = ~clk;

   wd_supervisor #(
      .N_SRC(2), .HOLD_CYCLES(4), .SETTLE_CYCLES(3),
      .MAX_RETRIES(2), .HEALTHY_BEATS(2), .CNT_W(16)
   ) dut (
      .clk(clk), .rstn(rstn), .src_alive(src_alive), .arm_req(arm_req),
      .clear_lockout(clear_lockout), .wd_triggered(wd_triggered), .wd_warning(wd_warning),
      .wd_heartbeat(wd_heartbeat), .wd_enable(wd_enable), .wd_force_reset(wd_force_reset),
      .rf_mute(rf_mute), .sub_rstn(sub_rstn), .warn_irq(warn_irq), .state(state),
      .retry_count(retry_count), .lockout(lockout)
   );

   typedef struct packed {
      logic [1:0] src;
      logic       arm, clr, trig, warn;
      logic [2:0] st;
      logic       hb, frc, wirq;
      logic [7:0] retry;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   vec_idx = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] src, input logic arm, input logic clr, input logic trig,
                      input logic w, input logic [2:0] st, input logic hb, input logic frc,
                      input logic wirq, input logic [7:0] retry);
      vec_t v;
      v.src = src; v.arm = arm; v.clr = clr; v.trig = trig; v.warn = w;
      v.st = st; v.hb = hb; v.frc = frc; v.wirq = wirq; v.retry = retry;
      vecs.push_back(v);
   endtask

   // Trigger from ARMED, then 4 HOLD, 3 SETTLE and the exit cycle.
   task automatic add_recovery(input logic arm_trig, input logic arm_exit,
                               input logic [7:0] r_before, input logic [7:0] r_after,
                               input logic [2:0] st_after);
      add(2'b00, arm_trig, 1'b0, 1'b1, 1'b0, ST_MUTE, 1'b0, 1'b0, 1'b0, r_before);
      for (int i = 0; i < 4; i++)
         add(2'b11, i[0], 1'b0, 1'b1, 1'b0, ST_HOLD, 1'b0, (i == 0), 1'b0, r_before);
      for (int i = 0; i < 3; i++)
         add(2'b11, arm_exit, 1'b1, 1'b0, 1'b0, ST_SETTLE, 1'b0, 1'b0, 1'b0, r_before);
      add(2'b00, arm_exit, 1'b0, 1'b0, 1'b0, st_after, 1'b0, (st_after == ST_ARMED), 1'b0, r_after);
   endtask

   task automatic check_outputs(input string tag, input vec_t e);
      logic en, mute, srst, lock;
      en   = (e.st == ST_ARMED);
      mute = (e.st != ST_ARMED);
      srst = (e.st != ST_HOLD);
      lock = (e.st == ST_LOCKOUT);
      chk({tag, ".state"},    {5'b0, state},          {5'b0, e.st});
      chk({tag, ".hb"},       {7'b0, wd_heartbeat},   {7'b0, e.hb});
      chk({tag, ".enable"},   {7'b0, wd_enable},      {7'b0, en});
      chk({tag, ".force"},    {7'b0, wd_force_reset}, {7'b0, e.frc});
      chk({tag, ".rf_mute"},  {7'b0, rf_mute},        {7'b0, mute});
      chk({tag, ".sub_rstn"}, {7'b0, sub_rstn},       {7'b0, srst});
      chk({tag, ".warn_irq"}, {7'b0, warn_irq},       {7'b0, e.wirq});
      chk({tag, ".retry"},    retry_count,            e.retry);
      chk({tag, ".lockout"},  {7'b0, lockout},        {7'b0, lock});
   endtask

   task automatic run_vecs();
      vec_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         src_alive     = vecs[i].src;
         arm_req       = vecs[i].arm;
         clear_lockout = vecs[i].clr;
         wd_triggered  = vecs[i].trig;
         wd_warning    = vecs[i].warn;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            chk($sformatf("vec%0d.scoreboard", vec_idx), 8'd0, 8'd1);
         end else begin
            e = exp_q.pop_front();
            check_outputs($sformatf("vec%0d", vec_idx), e);
         end
         vec_idx++;
      end
      vecs.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".state"},    {5'b0, state},          8'd0);
      chk({tag, ".hb"},       {7'b0, wd_heartbeat},   8'd0);
      chk({tag, ".enable"},   {7'b0, wd_enable},      8'd0);
      chk({tag, ".force"},    {7'b0, wd_force_reset}, 8'd0);
      chk({tag, ".rf_mute"},  {7'b0, rf_mute},        8'd1);
      chk({tag, ".sub_rstn"}, {7'b0, sub_rstn},       8'd0);
      chk({tag, ".warn_irq"}, {7'b0, warn_irq},       8'd0);
      chk({tag, ".retry"},    retry_count,            8'd0);
      chk({tag, ".lockout"},  {7'b0, lockout},        8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: run did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("release.sub_rstn_before_clk", {7'b0, sub_rstn}, 8'd0);
      @(posedge clk);
      #1;
      chk("release.sub_rstn_first_clk", {7'b0, sub_rstn}, 8'd1);
      chk("release.state", {5'b0, state}, 8'd0);

      //  src    arm   clr   trig  warn  state      hb    frc   wirq  retry
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b1, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd0);
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd0);
      add(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, ST_ARMED,  1'b0, 1'b0, 1'b1, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add_recovery(1'b1, 1'b1, 8'd0, 8'd1, ST_ARMED);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd1);
      add_recovery(1'b1, 1'b1, 8'd1, 8'd2, ST_LOCKOUT);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, ST_LOCKOUT, 1'b0, 1'b0, 1'b0, 8'd2);
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ST_LOCKOUT, 1'b0, 1'b0, 1'b0, 8'd2);
      add(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b1, 1'b0, 8'd0);
      add_recovery(1'b1, 1'b1, 8'd0, 8'd1, ST_ARMED);
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd1);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd1);
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b1, 1'b0, 1'b0, 8'd1);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b1, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, ST_MUTE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_HOLD,   1'b0, 1'b1, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_HOLD,   1'b0, 1'b0, 1'b0, 8'd0);
      run_vecs();

      // Asynchronous reset in the middle of HOLD.
      #2 rstn = 1'b0;
      #1;
      check_reset("midhold_reset");
      @(negedge clk);
      rstn = 1'b1;

      add(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 8'd0);
      add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ARMED,  1'b0, 1'b1, 1'b0, 8'd0);
      add_recovery(1'b0, 1'b0, 8'd0, 8'd1, ST_IDLE);
      run_vecs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wd_supervisor.md
Name: wd_supervisor

Overview:
- Controller that sequences the `watchdog_timer` block.
- Aggregates liveness pulses from N firmware/datapath sources into a single watchdog heartbeat.
- Arms and disarms the watchdog from a control-register level.
- On watchdog expiry, runs a safe-recovery sequence: mute RF, hold the subsystem in reset, settle, re-arm. Locks out after repeated failures.
- Sits between the AM-radio control registers / DSP subsystem and `watchdog_timer`.

Parameters:
- N_SRC, 4, number of liveness sources; all must check in per heartbeat.
- HOLD_CYCLES, 1024, cycles `sub_rstn` is held low during recovery (≥1).
- SETTLE_CYCLES, 256, cycles after reset release before re-arming (≥1).
- MAX_RETRIES, 3, recoveries allowed before LOCKOUT (1..255).
- HEALTHY_BEATS, 8, consecutive emitted heartbeats in ARMED that clear `retry_count` (≥1).
- CNT_W, 16, width of the hold/settle counter; must hold max(HOLD_CYCLES, SETTLE_CYCLES).

Ports:
- clk, in, 1, system clock; single clock domain.
- rstn, in, 1, asynchronous active-low reset.
- src_alive, in, N_SRC, per-source one-cycle liveness pulse.
- arm_req, in, 1, level from control register; 1 = watchdog supervision wanted.
- clear_lockout, in, 1, one-cycle pulse; exits LOCKOUT.
- wd_triggered, in, 1, watchdog expiry flag.
- wd_warning, in, 1, watchdog warning flag.
- wd_heartbeat, out, 1, one-cycle kick to the watchdog.
- wd_enable, out, 1, watchdog enable.
- wd_force_reset, out, 1, one-cycle pulse that clears the watchdog's counter/triggered state.
- rf_mute, out, 1, forces the RF output to zero.
- sub_rstn, out, 1, active-low reset to the DSP subsystem.
- warn_irq, out, 1, one-cycle pulse on the rising edge of `wd_warning` while ARMED.
- state, out, 3, current FSM state encoding.
- retry_count, out, 8, recoveries since last clear.
- lockout, out, 1, 1 while in LOCKOUT.

Behaviour:
- Reset (rstn=0, async):
  - state=IDLE, `wd_enable`=0, `wd_heartbeat`=0, `wd_force_reset`=0, `rf_mute`=1, `sub_rstn`=0, `warn_irq`=0, `retry_count`=0, `lockout`=0.
  - Seen vector, beat counter and hold/settle counter = 0.
  - `sub_rstn` deasserts synchronously on the first clock after rstn rises.
- All outputs are registered.
- Aggregation (ARMED only; elsewhere the seen vector is held at 0):
  - `seen |= src_alive` every cycle.
  - When `seen | src_alive` is all-ones: `wd_heartbeat`=1 on the next cycle, and seen loads 0.
  - Pulses arriving in that clearing cycle are already consumed by it; they are not carried forward.
  - Heartbeat latency from the completing pulse is 1 cycle.
- FSM states: IDLE=0, ARMED=1, MUTE=2, HOLD=3, SETTLE=4, LOCKOUT=5.
- IDLE: `wd_enable`=0, `rf_mute`=1, `sub_rstn`=1.
  - arm_req=1 → ARMED, with a 1-cycle `wd_force_reset` pulse on entry.
- ARMED: `wd_enable`=1, `rf_mute`=0.
  - wd_triggered=1 → MUTE. Takes priority over arm_req=0.
  - arm_req=0 → IDLE.
  - Beat counter increments per emitted heartbeat. At HEALTHY_BEATS: `retry_count`=0, counter=0.
  - Beat counter clears on ARMED entry.
- MUTE (1 cycle): `rf_mute`=1, `wd_enable`=0 → HOLD.
- HOLD: `sub_rstn`=0; `wd_force_reset`=1 in the first HOLD cycle only.
  - Counts HOLD_CYCLES, then → SETTLE.
- SETTLE: `sub_rstn`=1, `rf_mute`=1. Counts SETTLE_CYCLES.
  - On exit, `retry_count`+1 (saturating at 255).
  - If the new value ≥ MAX_RETRIES → LOCKOUT.
  - Else if arm_req → ARMED (with force_reset pulse).
  - Else → IDLE.
- LOCKOUT: `lockout`=1, `rf_mute`=1, `wd_enable`=0, `sub_rstn`=1.
  - clear_lockout → IDLE, with `retry_count`=0.
  - arm_req has no effect in LOCKOUT.
- Recovery in progress (MUTE/HOLD/SETTLE):
  - arm_req changes are ignored until SETTLE exit.
  - wd_triggered is ignored outside ARMED.
- `warn_irq`: `wd_warning` & ~`wd_warning_q` & (state==ARMED).

Decomposition:
- Package `wd_pkg` holds:
  - the state enum typedef (3-bit) with the encodings above;
  - the `retry_count` width constant (8).
- One sub-module, `wd_hb_aggregator`:
  - parameter N_SRC;
  - ports `clk`, `rstn`, `en`, `src_alive`, `hb_out`;
  - contains the seen-vector logic.
- FSM and counters stay in `wd_supervisor`.

Test Plan (sim params: N_SRC=2, HOLD=4, SETTLE=3, MAX_RETRIES=2, HEALTHY_BEATS=2):
- Reset, then arm_req=1 → state 0→1, `wd_force_reset` pulses for 1 cycle, `rf_mute` 1→0, `wd_enable`=1.
- ARMED: src_alive=01 at cycle t, 10 at t+3 → `wd_heartbeat`=1 only at t+4. src_alive=11 → heartbeat the next cycle, seen=0.
- wd_triggered=1 in ARMED → MUTE 1 cycle, then `sub_rstn`=0 for 4 cycles (force_reset in first), then SETTLE 3 cycles, re-arm; `retry_count`=1.
- Second trigger → after SETTLE, state=5, `lockout`=1, arm_req ignored; clear_lockout → IDLE, `retry_count`=0.
- After one recovery, 2 heartbeats in ARMED → `retry_count` 1→0.
- rstn asserted mid-HOLD → immediately IDLE, `sub_rstn`=0, `rf_mute`=1; wd_triggered and arm_req=0 in the same ARMED cycle → MUTE.
